// File: rtl/ctrl_sequencer.sv
`timescale 1ns/1ps
// ctrl_sequencer
//   Multi-cycle control sequencer for the 32-bit datapath CPU. Steps through
//   fetch (T0..T2) and an opcode-dependent execute phase (T3..T7). On each
//   step it raises the strobes for the common bus, the register file, the
//   ALU and the RAM. It also adds a RAM wait-state handshake with a timeout,
//   a single-step debug mode, and a trap on illegal opcodes.
//
// Ports
//   clk, Reset       rising-edge clock; asynchronous active-high reset
//   Stop             level; halts at the next instruction boundary
//   step_mode        1: pause before every fetch until step_go
//   step_go          1-cycle pulse; releases one instruction from S_PAUSE
//   ir               instruction register; opcode = ir[IR_W-1 -: 5]
//   CONFFOut         branch-condition flip-flop
//   mem_ready        RAM handshake (see the handshake note below)
//   run, fault       registered status; fault is sticky until Reset
//   Gra..IncPC       register-file / RAM / ALU single-bit strobes
//   bus_sel[7:0]     one-hot bus driver: PC,Zlow,Zhigh,MDR,HI,LO,InPort,C
//   enable[9:0]      register loads: MAR,PC,MDR,IR,Y,Z,HI,LO,OutPort,CON
//   alu_op[4:0]      ALU operation for the step that loads Z
//   state_dbg[3:0]   current FSM state encoding (debug)
//   wait_cnt[7:0]    current RAM stall count (debug)
//
// Handshake: a step that asserts ReadRAM or WriteRAM completes on the rising
// edge where mem_ready=1. While mem_ready=0 the step repeats with the same
// strobes and wait_cnt counts the stalled cycles. On the WAIT_MAX-th stall
// cycle the next edge enters S_FAULT.
module ctrl_sequencer #(
  parameter int IR_W     = 32,
  parameter int WAIT_MAX = 15,
  parameter int TRAP_EN  = 1
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Stop,
  input  logic            step_mode,
  input  logic            step_go,
  input  logic [IR_W-1:0] ir,
  input  logic            CONFFOut,
  input  logic            mem_ready,
  output logic            run,
  output logic            fault,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            ReadRAM,
  output logic            WriteRAM,
  output logic            MD_Read,
  output logic            IncPC,
  output logic [7:0]      bus_sel,
  output logic [9:0]      enable,
  output logic [4:0]      alu_op,
  output logic [3:0]      state_dbg,
  output logic [7:0]      wait_cnt
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_PAUSE = 4'd1,
    S_T0 = 4'd2, S_T1 = 4'd3, S_T2 = 4'd4, S_T3 = 4'd5,
    S_T4 = 4'd6, S_T5 = 4'd7, S_T6 = 4'd8, S_T7 = 4'd9,
    S_HALT = 4'd10, S_FAULT = 4'd11
  } state_t;

  // bus_sel bit positions
  localparam int B_PC = 0, B_ZL = 1, B_ZH = 2, B_MDR = 3, B_HI = 4, B_LO = 5, B_IN = 6, B_C = 7;
  // enable bit positions
  localparam int E_MAR = 0, E_PC = 1, E_MDR = 2, E_IR = 3, E_Y = 4, E_Z = 5,
                 E_HI = 6, E_LO = 7, E_OUT = 8, E_CON = 9;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_MUL = 5'd15,
                         OP_DIV = 5'd16, OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19,
                         OP_JR = 5'd20, OP_JAL = 5'd21, OP_IN = 5'd22, OP_OUT = 5'd23,
                         OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP = 5'd26, OP_HALT = 5'd27;
  localparam logic [4:0] ALU_ADD = 5'd3;
  localparam logic [7:0] W_LAST  = 8'(WAIT_MAX - 1);

  state_t     state, state_next;
  logic [7:0] w;
  logic [4:0] op;
  logic       illegal, last, halt_step, trap_step, ram_step, is_t;
  logic       unused_ir;

  assign op        = ir[IR_W-1 -: 5];
  assign unused_ir = ^ir[IR_W-6:0];
  assign illegal   = (op >= 5'd28);
  assign is_t      = (state >= S_T0) && (state <= S_T7);
  assign ram_step  = ReadRAM | WriteRAM;
  assign state_dbg = state;
  assign wait_cnt  = w;

  // Moore decode of state + opcode. last marks the final step of an instruction.
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    ReadRAM = 1'b0; WriteRAM = 1'b0; MD_Read = 1'b0; IncPC = 1'b0;
    bus_sel = '0; enable = '0; alu_op = '0;
    last = 1'b0; halt_step = 1'b0; trap_step = 1'b0;
    case (state)
      S_T0: begin bus_sel[B_PC] = 1'b1; enable[E_MAR] = 1'b1; enable[E_Z] = 1'b1; IncPC = 1'b1; end
      S_T1: begin
        bus_sel[B_ZL] = 1'b1; enable[E_PC] = 1'b1; enable[E_MDR] = 1'b1;
        ReadRAM = 1'b1; MD_Read = 1'b1;
      end
      S_T2: begin
        bus_sel[B_MDR] = 1'b1; enable[E_IR] = 1'b1;
        if (op == OP_NOP) last = 1'b1;
        else if (illegal) begin
          if (TRAP_EN != 0) trap_step = 1'b1;
          else last = 1'b1;
        end
      end
      S_T3: case (op) inside
        OP_LD, OP_ST:     begin Grb = 1'b1; BAout = 1'b1; enable[E_Y] = 1'b1; end
        OP_LDI:           begin Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; enable[E_Y] = 1'b1; end
        [5'd3:5'd14]:     begin Grb = 1'b1; Rout = 1'b1; enable[E_Y] = 1'b1; end
        OP_MUL, OP_DIV:   begin Gra = 1'b1; Rout = 1'b1; enable[E_Y] = 1'b1; end
        OP_NEG, OP_NOT:   begin Grb = 1'b1; Rout = 1'b1; enable[E_Z] = 1'b1; alu_op = op; end
        OP_BR:            begin Grb = 1'b1; Rout = 1'b1; enable[E_CON] = 1'b1; end
        OP_JR:            begin Gra = 1'b1; Rout = 1'b1; enable[E_PC] = 1'b1; last = 1'b1; end
        OP_JAL:           begin bus_sel[B_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1; end
        OP_IN:            begin bus_sel[B_IN] = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
        OP_OUT:           begin Gra = 1'b1; Rout = 1'b1; enable[E_OUT] = 1'b1; last = 1'b1; end
        OP_MFHI:          begin bus_sel[B_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
        OP_MFLO:          begin bus_sel[B_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
        OP_HALT:          halt_step = 1'b1;
        default:          last = 1'b1;
      endcase
      S_T4: case (op) inside
        [5'd3:5'd11]:     begin Grc = 1'b1; Rout = 1'b1; enable[E_Z] = 1'b1; alu_op = op; end
        OP_MUL, OP_DIV:   begin Grb = 1'b1; Rout = 1'b1; enable[E_Z] = 1'b1; alu_op = op; end
        [5'd12:5'd14]:    begin bus_sel[B_C] = 1'b1; enable[E_Z] = 1'b1; alu_op = op; end
        OP_LD, OP_LDI, OP_ST: begin bus_sel[B_C] = 1'b1; enable[E_Z] = 1'b1; alu_op = ALU_ADD; end
        OP_NEG, OP_NOT:   begin bus_sel[B_ZL] = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
        OP_BR:            begin bus_sel[B_PC] = 1'b1; enable[E_Y] = 1'b1; end
        OP_JAL:           begin Gra = 1'b1; Rout = 1'b1; enable[E_PC] = 1'b1; last = 1'b1; end
        default:          last = 1'b1;
      endcase
      S_T5: case (op) inside
        OP_LDI, [5'd3:5'd14]: begin bus_sel[B_ZL] = 1'b1; Gra = 1'b1; Rin = 1'b1; last = 1'b1; end
        OP_LD:            begin bus_sel[B_ZL] = 1'b1; enable[E_MAR] = 1'b1; end
        OP_ST:            begin
          bus_sel[B_ZL] = 1'b1; enable[E_MAR] = 1'b1;
          Gra = 1'b1; Rout = 1'b1; enable[E_MDR] = 1'b1;
        end
        OP_MUL, OP_DIV:   begin bus_sel[B_ZL] = 1'b1; enable[E_LO] = 1'b1; end
        OP_BR:            begin bus_sel[B_C] = 1'b1; enable[E_Z] = 1'b1; alu_op = ALU_ADD; end
        default:          last = 1'b1;
      endcase
      S_T6: case (op) inside
        OP_LD:            begin ReadRAM = 1'b1; MD_Read = 1'b1; enable[E_MDR] = 1'b1; end
        OP_ST:            begin WriteRAM = 1'b1; last = 1'b1; end
        OP_MUL, OP_DIV:   begin bus_sel[B_ZH] = 1'b1; enable[E_HI] = 1'b1; last = 1'b1; end
        // Taken branch: PC loads the computed target only when the condition holds.
        OP_BR:            begin bus_sel[B_ZL] = 1'b1; enable[E_PC] = CONFFOut; last = 1'b1; end
        default:          last = 1'b1;
      endcase
      S_T7: begin
        if (op == OP_LD) begin bus_sel[B_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        last = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = step_mode ? S_PAUSE : S_T0;
      S_PAUSE: if (step_go) state_next = S_T0;
      S_HALT, S_FAULT: state_next = state;
      default: begin
        if (ram_step && !mem_ready)
          state_next = (w == W_LAST) ? S_FAULT : state;
        else if (trap_step) state_next = S_FAULT;
        else if (halt_step) state_next = S_HALT;
        else if (last) state_next = Stop ? S_HALT : (step_mode ? S_PAUSE : S_T0);
        else state_next = state_t'(state + 4'd1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_RESET;
      w     <= '0;
      run   <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      w     <= (is_t && ram_step && !mem_ready && state_next != S_FAULT) ? w + 8'd1 : 8'd0;
      run   <= (state_next >= S_T0) && (state_next <= S_T7);
      fault <= fault | (state_next == S_FAULT);
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
`timescale 1ns/1ps
module tb_ctrl_sequencer;

  logic        clk = 1'b0, Reset = 1'b1, Stop = 1'b0, step_mode = 1'b0, step_go = 1'b0;
  logic        CONFFOut = 1'b0, mem_ready = 1'b1;
  logic [31:0] ir = '0;
  logic        run, fault, Gra, Grb, Grc, Rin, Rout, BAout, ReadRAM, WriteRAM, MD_Read, IncPC;
  logic [7:0]  bus_sel;
  logic [9:0]  enable;
  logic [4:0]  alu_op;
  logic [3:0]  state_dbg;
  logic [7:0]  wait_cnt;

  ctrl_sequencer #(.IR_W(32), .WAIT_MAX(15), .TRAP_EN(1)) dut (
    .clk(clk), .Reset(Reset), .Stop(Stop), .step_mode(step_mode), .step_go(step_go),
    .ir(ir), .CONFFOut(CONFFOut), .mem_ready(mem_ready), .run(run), .fault(fault),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ReadRAM(ReadRAM), .WriteRAM(WriteRAM), .MD_Read(MD_Read), .IncPC(IncPC),
    .bus_sel(bus_sel), .enable(enable), .alu_op(alu_op), .state_dbg(state_dbg),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  // state encodings
  localparam logic [3:0] ST_RESET = 4'd0, ST_PAUSE = 4'd1, T0 = 4'd2, T1 = 4'd3, T2 = 4'd4,
                         T3 = 4'd5, T4 = 4'd6, T5 = 4'd7, T6 = 4'd8, T7 = 4'd9,
                         ST_HALT = 4'd10, ST_FAULT = 4'd11;
  // bus_sel one-hot
  localparam logic [7:0] B_PC = 8'h01, B_ZL = 8'h02, B_ZH = 8'h04, B_MDR = 8'h08,
                         B_HI = 8'h10, B_LO = 8'h20, B_IN = 8'h40, B_C = 8'h80;
  // enable bits
  localparam logic [9:0] E_MAR = 10'h001, E_PC = 10'h002, E_MDR = 10'h004, E_IR = 10'h008,
                         E_Y = 10'h010, E_Z = 10'h020, E_HI = 10'h040, E_LO = 10'h080,
                         E_OUT = 10'h100, E_CON = 10'h200;
  // flags = {Gra,Grb,Grc,Rin,Rout,BAout,ReadRAM,WriteRAM,MD_Read,IncPC}
  localparam logic [9:0] F_GRA = 10'h200, F_GRB = 10'h100, F_GRC = 10'h080, F_RIN = 10'h040,
                         F_ROUT = 10'h020, F_BA = 10'h010, F_RD = 10'h008, F_WR = 10'h004,
                         F_MDRD = 10'h002, F_INC = 10'h001;

  typedef struct {
    logic [4:0] op;
    logic [3:0] st;
    logic [7:0] bus;
    logic [9:0] en;
    logic [9:0] fl;
    logic [4:0] alu;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [9:0] flags_now();
    return {Gra, Grb, Grc, Rin, Rout, BAout, ReadRAM, WriteRAM, MD_Read, IncPC};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [3:0] st, input logic [7:0] bus,
                         input logic [9:0] en, input logic [9:0] fl, input logic [4:0] alu);
    vec_t v;
    v.op = op; v.st = st; v.bus = bus; v.en = en; v.fl = fl; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [4:0] op);
    add_vec(op, T0, B_PC,  E_MAR | E_Z,  F_INC,          5'd0);
    add_vec(op, T1, B_ZL,  E_PC | E_MDR, F_RD | F_MDRD,  5'd0);
    add_vec(op, T2, B_MDR, E_IR,         10'h0,          5'd0);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_strobes"}, {31'd0, bus_sel, enable, flags_now(), alu_op}, 64'd0);
    chk({name, "_run"}, {63'd0, run}, 64'd0);
  endtask

  // Advance until the FSM shows state s; an expired budget counts as a failure.
  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", {60'd0, state_dbg}, {60'd0, s});
  endtask

  task automatic do_reset(input logic sm);
    Reset = 1'b1;
    tick();
    step_mode = sm;
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    Reset = 1'b1;
    tick(); tick();
    chk("reset_state", {60'd0, state_dbg}, {60'd0, ST_RESET});
    chk("reset_fault", {63'd0, fault}, 64'd0);
    chk("reset_wait", {56'd0, wait_cnt}, 64'd0);
    chk_idle("reset");

    // Straight-line program with mem_ready=1 throughout
    add_fetch(5'd3);
    add_vec(5'd3, T3, 8'h0, E_Y, F_GRB | F_ROUT, 5'd0);
    add_vec(5'd3, T4, 8'h0, E_Z, F_GRC | F_ROUT, 5'd3);
    add_vec(5'd3, T5, B_ZL, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd15);
    add_vec(5'd15, T3, 8'h0, E_Y, F_GRA | F_ROUT, 5'd0);
    add_vec(5'd15, T4, 8'h0, E_Z, F_GRB | F_ROUT, 5'd15);
    add_vec(5'd15, T5, B_ZL, E_LO, 10'h0, 5'd0);
    add_vec(5'd15, T6, B_ZH, E_HI, 10'h0, 5'd0);
    add_fetch(5'd17);
    add_vec(5'd17, T3, 8'h0, E_Z, F_GRB | F_ROUT, 5'd17);
    add_vec(5'd17, T4, B_ZL, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd21);
    add_vec(5'd21, T3, B_PC, 10'h0, F_GRB | F_RIN, 5'd0);
    add_vec(5'd21, T4, 8'h0, E_PC, F_GRA | F_ROUT, 5'd0);
    add_fetch(5'd22);
    add_vec(5'd22, T3, B_IN, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd23);
    add_vec(5'd23, T3, 8'h0, E_OUT, F_GRA | F_ROUT, 5'd0);
    add_fetch(5'd24);
    add_vec(5'd24, T3, B_HI, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd25);
    add_vec(5'd25, T3, B_LO, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd12);
    add_vec(5'd12, T3, 8'h0, E_Y, F_GRB | F_ROUT, 5'd0);
    add_vec(5'd12, T4, B_C, E_Z, 10'h0, 5'd12);
    add_vec(5'd12, T5, B_ZL, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd1);
    add_vec(5'd1, T3, 8'h0, E_Y, F_GRB | F_ROUT | F_BA, 5'd0);
    add_vec(5'd1, T4, B_C, E_Z, 10'h0, 5'd3);
    add_vec(5'd1, T5, B_ZL, 10'h0, F_GRA | F_RIN, 5'd0);
    add_fetch(5'd26);
    add_fetch(5'd20);
    add_vec(5'd20, T3, 8'h0, E_PC, F_GRA | F_ROUT, 5'd0);

    Reset = 1'b0;
    tick();
    foreach (vecs[i]) begin
      ir = {vecs[i].op, 27'd0};
      if (i == 0) ir = 32'h19888000;
      #1;
      chk($sformatf("vec%0d_op%0d_st%0d", i, vecs[i].op, vecs[i].st),
          {25'd0, state_dbg, run, fault, bus_sel, enable, flags_now(), alu_op},
          {25'd0, vecs[i].st, 1'b1, 1'b0, vecs[i].bus, vecs[i].en, vecs[i].fl, vecs[i].alu});
      tick();
    end

    // ld with three stalled cycles in T6
    ir = 32'd0;
    wait_state(T6, 10);
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      chk($sformatf("ld_stall%0d", k),
          {40'd0, state_dbg, bus_sel, enable, flags_now()},
          {40'd0, T6, 8'h0, E_MDR, F_RD | F_MDRD});
      chk($sformatf("ld_wait%0d", k), {56'd0, wait_cnt}, 64'(k));
      tick();
    end
    chk("ld_t7", {40'd0, state_dbg, bus_sel, enable, flags_now()},
        {40'd0, T7, B_MDR, 10'h0, F_GRA | F_RIN});
    chk("ld_wait_clear", {56'd0, wait_cnt}, 64'd0);

    // Stop during add finishes the instruction, then halts
    tick();
    ir = 32'h19888000;
    wait_state(T4, 6);
    Stop = 1'b1;
    tick();
    chk("stop_t5", {60'd0, state_dbg}, {60'd0, T5});
    tick();
    chk("stop_halt", {60'd0, state_dbg}, {60'd0, ST_HALT});
    chk_idle("halt");
    step_go = 1'b1;
    tick(); tick();
    step_go = 1'b0;
    chk("halt_sticky", {60'd0, state_dbg}, {60'd0, ST_HALT});
    Stop = 1'b0;

    // br not taken, then taken
    do_reset(1'b0);
    ir = {5'd19, 27'd0};
    CONFFOut = 1'b0;
    wait_state(T6, 10);
    chk("br_not_taken", {54'd0, enable}, 64'd0);
    tick();
    CONFFOut = 1'b1;
    wait_state(T6, 10);
    chk("br_taken", {54'd0, enable}, {54'd0, E_PC});
    CONFFOut = 1'b0;

    // Reset during T4 of mul aborts asynchronously
    tick();
    ir = {5'd15, 27'd0};
    wait_state(T4, 10);
    chk("mul_t4", {54'd0, enable}, {54'd0, E_Z});
    Reset = 1'b1;
    #1;
    chk("async_rst_state", {60'd0, state_dbg}, {60'd0, ST_RESET});
    chk_idle("async_rst");

    // Fetch stall with mem_ready stuck low times out
    do_reset(1'b0);
    mem_ready = 1'b0;
    wait_state(T1, 5);
    repeat (14) tick();
    chk("timeout_last_stall", {52'd0, state_dbg, wait_cnt}, {52'd0, T1, 8'd14});
    tick();
    chk("timeout_fault_state", {60'd0, state_dbg}, {60'd0, ST_FAULT});
    chk("timeout_fault", {63'd0, fault}, 64'd1);
    chk_idle("timeout");
    mem_ready = 1'b1;
    tick(); tick();
    chk("fault_sticky", {63'd0, fault}, 64'd1);

    // Single-step mode
    ir = {5'd26, 27'd0};
    do_reset(1'b1);
    chk("pause_entry", {59'd0, state_dbg, run}, {59'd0, ST_PAUSE, 1'b0});
    repeat (4) tick();
    chk("pause_hold", {59'd0, state_dbg, run}, {59'd0, ST_PAUSE, 1'b0});
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    chk("step_t0", {59'd0, state_dbg, run}, {59'd0, T0, 1'b1});
    tick();
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    chk("step_t2", {60'd0, state_dbg}, {60'd0, T2});
    tick();
    chk("step_back_pause", {59'd0, state_dbg, run}, {59'd0, ST_PAUSE, 1'b0});
    tick();
    chk("step_wait", {60'd0, state_dbg}, {60'd0, ST_PAUSE});
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    chk("step_second", {60'd0, state_dbg}, {60'd0, T0});

    // Illegal opcode traps after T2
    ir = {5'd30, 27'd0};
    do_reset(1'b0);
    wait_state(T2, 5);
    tick();
    chk("trap_state", {60'd0, state_dbg}, {60'd0, ST_FAULT});
    chk("trap_fault", {62'd0, fault, run}, {62'd0, 1'b1, 1'b0});

    // halt opcode
    ir = {5'd27, 27'd0};
    do_reset(1'b0);
    wait_state(T3, 6);
    chk("halt_t3_run", {63'd0, run}, 64'd1);
    tick();
    chk("halt_op", {58'd0, state_dbg, run, fault}, {58'd0, ST_HALT, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
